// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_we;
        logic pc_sel;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Stick at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32 pipeline: merges hazard,
// redirect and bus events into stage enables, bubbles and PC redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_use_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  if_done_i,
    input  logic                  mem_req_i,
    input  logic                  mem_done_i,
    output logic                  pc_we_o,
    output logic                  pc_sel_o,
    output logic [ADDR_WIDTH-1:0] pc_redirect_o,
    output logic                  ifid_we_o,
    output logic                  idex_we_o,
    output logic                  exmem_we_o,
    output logic                  memwb_we_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  memwb_flush_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    ctrl_state_t           state_q;
    ctrl_state_t           state_d;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] target_d;
    stage_ctrl_t           ctrl;
    logic                  mem_stall;
    logic                  redirect_accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        ctrl            = '0;
        redirect_accept = 1'b0;
        mem_stall       = mem_req_i && !mem_done_i;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    // A branch in EX stays put and re-presents once the bus frees.
                    ctrl.memwb_flush = 1'b1;
                end else if (branch_taken_i) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_we   = 1'b1;
                    ctrl.memwb_we   = 1'b1;
                    redirect_accept = 1'b1;
                    if (if_done_i) begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = 1'b1;
                    end else begin
                        target_d = branch_target_i;
                        state_d  = DRAIN;
                    end
                end else if (load_use_i) begin
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_we   = 1'b1;
                    ctrl.memwb_we   = 1'b1;
                end else if (!if_done_i) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_we    = 1'b1;
                    ctrl.exmem_we   = 1'b1;
                    ctrl.memwb_we   = 1'b1;
                end else begin
                    ctrl.pc_we    = 1'b1;
                    ctrl.ifid_we  = 1'b1;
                    ctrl.idex_we  = 1'b1;
                    ctrl.exmem_we = 1'b1;
                    ctrl.memwb_we = 1'b1;
                end
            end
            DRAIN: begin
                // Wrong-path fetch is discarded; redirect lands once the bus returns.
                ctrl.ifid_flush = 1'b1;
                if (if_done_i) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = 1'b1;
                    state_d     = RUN;
                end
                if (mem_stall) begin
                    ctrl.memwb_flush = 1'b1;
                end else begin
                    ctrl.idex_we  = 1'b1;
                    ctrl.exmem_we = 1'b1;
                    ctrl.memwb_we = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset forces bubbles everywhere regardless of state.
        if (!rst_ni) begin
            ctrl             = '0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.memwb_flush = 1'b1;
            redirect_accept  = 1'b0;
        end
    end

    assign pc_we_o       = ctrl.pc_we;
    assign pc_sel_o      = ctrl.pc_sel;
    assign ifid_we_o     = ctrl.ifid_we;
    assign idex_we_o     = ctrl.idex_we;
    assign exmem_we_o    = ctrl.exmem_we;
    assign memwb_we_o    = ctrl.memwb_we;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_flush_o  = ctrl.idex_flush;
    assign memwb_flush_o = ctrl.memwb_flush;
    assign pc_redirect_o = (state_q == DRAIN) ? target_q : branch_target_i;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (!ctrl.pc_we),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (redirect_accept),
        .cnt_o  (flush_cnt_o)
    );

    a_no_branch_in_drain: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !((state_q == DRAIN) && branch_taken_i)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes reference-model
// expectations, a negedge monitor pops and compares against the DUT.
module tb_pipeline_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          load_use_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic [AW-1:0] branch_target_i = '0;
    logic          if_done_i = 1'b0;
    logic          mem_req_i = 1'b0;
    logic          mem_done_i = 1'b0;
    logic          pc_we_o, pc_sel_o;
    logic [AW-1:0] pc_redirect_o;
    logic          ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o;
    logic          ifid_flush_o, idex_flush_o, memwb_flush_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .load_use_i      (load_use_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .if_done_i       (if_done_i),
        .mem_req_i       (mem_req_i),
        .mem_done_i      (mem_done_i),
        .pc_we_o         (pc_we_o),
        .pc_sel_o        (pc_sel_o),
        .pc_redirect_o   (pc_redirect_o),
        .ifid_we_o       (ifid_we_o),
        .idex_we_o       (idex_we_o),
        .exmem_we_o      (exmem_we_o),
        .memwb_we_o      (memwb_we_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_flush_o    (idex_flush_o),
        .memwb_flush_o   (memwb_flush_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    typedef struct packed {
        logic          pc_we;
        logic          pc_sel;
        logic          ifid_we;
        logic          ifid_flush;
        logic          idex_we;
        logic          idex_flush;
        logic          exmem_we;
        logic          memwb_we;
        logic          memwb_flush;
        logic [AW-1:0] redirect;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
        int            tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: are we waiting for a wrong-path fetch, and where to go after.
    bit            m_waiting = 1'b0;
    logic [AW-1:0] m_dest    = '0;
    int            m_stalls  = 0;
    int            m_flushes = 0;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input bit lu, input bit bt, input logic [AW-1:0] tgt,
                         input bit ifd, input bit mreq, input bit mdone);
        exp_t e;
        bit   bus_busy;
        bit   took_branch;
        load_use_i      = lu;
        branch_taken_i  = bt;
        branch_target_i = tgt;
        if_done_i       = ifd;
        mem_req_i       = mreq;
        mem_done_i      = mdone;
        bus_busy        = mreq && !mdone;
        took_branch     = 1'b0;
        e               = '0;
        e.tag           = cyc;
        e.stall_cnt     = CW'(m_stalls);
        e.flush_cnt     = CW'(m_flushes);
        e.redirect      = m_waiting ? m_dest : tgt;
        if (m_waiting) begin
            e.ifid_flush = 1'b1;
            if (ifd) begin
                e.pc_we     = 1'b1;
                e.pc_sel    = 1'b1;
                m_waiting   = 1'b0;
            end
            if (bus_busy) e.memwb_flush = 1'b1;
            else {e.idex_we, e.exmem_we, e.memwb_we} = 3'b111;
        end else if (bus_busy) begin
            e.memwb_flush = 1'b1;
        end else if (bt) begin
            took_branch  = 1'b1;
            e.ifid_flush = 1'b1;
            e.idex_flush = 1'b1;
            e.exmem_we   = 1'b1;
            e.memwb_we   = 1'b1;
            if (ifd) begin
                e.pc_we  = 1'b1;
                e.pc_sel = 1'b1;
            end else begin
                m_waiting = 1'b1;
                m_dest    = tgt;
            end
        end else if (lu) begin
            e.idex_flush = 1'b1;
            e.exmem_we   = 1'b1;
            e.memwb_we   = 1'b1;
        end else if (!ifd) begin
            e.ifid_flush = 1'b1;
            {e.idex_we, e.exmem_we, e.memwb_we} = 3'b111;
        end else begin
            {e.pc_we, e.ifid_we, e.idex_we, e.exmem_we, e.memwb_we} = 5'b11111;
        end
        if (!e.pc_we) m_stalls = sat_inc(m_stalls);
        if (took_branch) m_flushes = sat_inc(m_flushes);
        exp_q.push_back(e);
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    // Reset asserted between edges for two cycles; model state is abandoned.
    task automatic reset_pulse(input logic [AW-1:0] tgt);
        exp_t e;
        branch_target_i = tgt;
        rst_ni          = 1'b0;
        m_waiting       = 1'b0;
        m_dest          = '0;
        m_stalls        = 0;
        m_flushes       = 0;
        for (int k = 0; k < 2; k++) begin
            e             = '0;
            e.tag         = cyc;
            e.ifid_flush  = 1'b1;
            e.idex_flush  = 1'b1;
            e.memwb_flush = 1'b1;
            e.redirect    = tgt;
            exp_q.push_back(e);
            cyc++;
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b1;
    endtask

    // Monitor: the controller presents a full control word every cycle.
    initial begin
        exp_t e;
        logic [8:0] got_c, exp_c;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_c = {pc_we_o, pc_sel_o, ifid_we_o, ifid_flush_o, idex_we_o,
                         idex_flush_o, exmem_we_o, memwb_we_o, memwb_flush_o};
                exp_c = {e.pc_we, e.pc_sel, e.ifid_we, e.ifid_flush, e.idex_we,
                         e.idex_flush, e.exmem_we, e.memwb_we, e.memwb_flush};
                checks++;
                if (got_c !== exp_c) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d got=%b exp=%b (pc_we,pc_sel,ifid_we,ifid_fl,idex_we,idex_fl,exmem_we,memwb_we,memwb_fl)",
                             e.tag, got_c, exp_c);
                end
                checks++;
                if (pc_redirect_o !== e.redirect) begin
                    errors++;
                    $display("FAIL redirect cyc=%0d got=%h exp=%h", e.tag, pc_redirect_o, e.redirect);
                end
                checks++;
                if (stall_cnt_o !== e.stall_cnt) begin
                    errors++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.tag, stall_cnt_o, e.stall_cnt);
                end
                checks++;
                if (flush_cnt_o !== e.flush_cnt) begin
                    errors++;
                    $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", e.tag, flush_cnt_o, e.flush_cnt);
                end
            end
        end
    end

    initial begin
        bit lu, bt, ifd, mreq, mdone;
        @(posedge clk_i);
        #1;
        reset_pulse(32'h0000_0000);

        // Load-use bubble then normal flow.
        cycle(1, 0, 32'h0, 1, 0, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Taken branch with fetch already done.
        cycle(0, 1, 32'h8000_0040, 1, 0, 0);
        cycle(0, 0, 32'h0000_0004, 1, 0, 0);

        // Branch while fetch outstanding: drain three cycles, then redirect.
        cycle(0, 1, 32'h8000_0100, 0, 0, 0);
        cycle(0, 0, 32'h1111_1110, 0, 0, 0);
        cycle(0, 0, 32'h2222_2220, 0, 0, 0);
        cycle(0, 0, 32'h3333_3330, 0, 0, 0);
        cycle(0, 0, 32'h4444_4440, 1, 0, 0);
        cycle(0, 0, 32'h5555_5550, 1, 0, 0);

        // Memory stall holds the branch until the bus completes.
        cycle(0, 1, 32'h8000_0200, 1, 1, 0);
        cycle(0, 1, 32'h8000_0200, 1, 1, 0);
        cycle(0, 1, 32'h8000_0200, 1, 1, 1);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Drain with memory stall and fetch returning together.
        cycle(0, 1, 32'h8000_0300, 0, 0, 0);
        cycle(0, 0, 32'h0, 0, 1, 0);
        cycle(0, 0, 32'h0, 1, 1, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Stall counter saturation.
        reset_pulse(32'h0000_0000);
        for (int i = 0; i < 20; i++) cycle(0, 0, 32'h0, 0, 0, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Flush counter saturation via repeated redirects.
        for (int i = 0; i < 18; i++) cycle(0, 1, 32'h8000_0000 + AW'(i * 4), 1, 0, 0);

        // Async reset mid-drain; stale target must not leak out afterwards.
        cycle(0, 1, 32'hDEAD_BEE0, 0, 0, 0);
        cycle(0, 0, 32'h0, 0, 0, 0);
        reset_pulse(32'h0000_1230);
        cycle(0, 0, 32'h0000_1234, 1, 0, 0);
        cycle(0, 0, 32'h0000_5678, 0, 0, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse($urandom);
            end else begin
                lu    = ($urandom_range(0, 5) == 0);
                bt    = m_waiting ? 1'b0 : ($urandom_range(0, 4) == 0);
                ifd   = ($urandom_range(0, 2) != 0);
                mreq  = ($urandom_range(0, 2) == 0);
                mdone = ($urandom_range(0, 1) == 0);
                cycle(lu, bt, $urandom, ifd, mreq, mdone);
            end
        end

        load_use_i     = 1'b0;
        branch_taken_i = 1'b0;
        mem_req_i      = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue got=%0d exp=0 entries left", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
